// File: rtl/led_mode_ctrl.sv
// Status LED mode controller.
// A debounced push-button steps the LED through OFF -> SOLID -> SLOW -> FAST.
// The block holds the button synchronizer, the debouncer, the mode FSM and
// the blink timebase. Every output is driven straight from a register.
module led_mode_ctrl #(
    parameter int half_freq = 50_000_000,   // clk cycles per SLOW half-period
    parameter int W         = 26,           // timebase counter width
    parameter int DB_CYCLES = 1_000_000,    // cycles a new level must persist
    parameter int DBW       = 20            // debounce counter width
) (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       mode_btn,
    output logic       LED,
    output logic [1:0] mode,
    output logic       tick
);

    // Mode encoding matches the value presented on the mode port.
    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_SOLID = 2'd1;
    localparam logic [1:0] ST_SLOW  = 2'd2;
    localparam logic [1:0] ST_FAST  = 2'd3;

    // Last counter value of a half-period; FAST blinks four times faster.
    localparam logic [W-1:0]   SLOW_TC = W'(half_freq - 1);
    localparam logic [W-1:0]   FAST_TC = W'((half_freq >> 2) - 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    // Button path state.
    logic           s1_reg;
    logic           s2_reg;
    logic           stable_reg;
    logic           stable_next;
    logic           stable_d_reg;
    logic [DBW-1:0] db_cnt_reg;
    logic [DBW-1:0] db_cnt_next;
    logic           press;

    // Mode and blink state.
    logic [1:0]     mode_reg;
    logic [1:0]     mode_next;
    logic [W-1:0]   cnt_reg;
    logic [W-1:0]   cnt_next;
    logic [W-1:0]   term_cnt;
    logic           led_reg;
    logic           led_next;
    logic           tick_reg;
    logic           tick_next;

    // Two-flop synchronizer bringing the asynchronous button into clk.
    always_ff @(posedge clk) begin
        if (rst_btn) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= mode_btn;
            s2_reg <= s1_reg;
        end
    end

    // Debounce: a new level is accepted only after DB_CYCLES consecutive
    // cycles of disagreement with the current stable level.
    always_comb begin
        stable_next = stable_reg;
        db_cnt_next = db_cnt_reg;
        if (s2_reg == stable_reg) begin
            db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
            stable_next = s2_reg;
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt_reg + 1'b1;
        end
    end

    // Debounce state plus the one-cycle delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst_btn) begin
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            db_cnt_reg   <= '0;
        end else begin
            stable_reg   <= stable_next;
            stable_d_reg <= stable_reg;
            db_cnt_reg   <= db_cnt_next;
        end
    end

    // Only the rising edge of the debounced level counts as a press.
    assign press = stable_reg & ~stable_d_reg;

    // Half-period length depends on which blink mode is active.
    assign term_cnt = (mode_reg == ST_FAST) ? FAST_TC : SLOW_TC;

    // Mode FSM and timebase. A press always wins over a terminal count:
    // the new mode starts with a cleared counter and its entry LED level.
    always_comb begin
        mode_next = mode_reg;
        cnt_next  = cnt_reg;
        led_next  = led_reg;
        tick_next = 1'b0;
        if (press) begin
            mode_next = mode_reg + 2'd1;
            cnt_next  = '0;
            led_next  = (mode_next != ST_OFF);
        end else if ((mode_reg == ST_SLOW) || (mode_reg == ST_FAST)) begin
            if (cnt_reg == term_cnt) begin
                cnt_next  = '0;
                led_next  = ~led_reg;
                tick_next = 1'b1;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end else begin
            cnt_next = '0;
            led_next = (mode_reg == ST_SOLID);
        end
    end

    // Registered mode, counter and outputs.
    always_ff @(posedge clk) begin
        if (rst_btn) begin
            mode_reg <= ST_OFF;
            cnt_reg  <= '0;
            led_reg  <= 1'b0;
            tick_reg <= 1'b0;
        end else begin
            mode_reg <= mode_next;
            cnt_reg  <= cnt_next;
            led_reg  <= led_next;
            tick_reg <= tick_next;
        end
    end

    assign LED  = led_reg;
    assign mode = mode_reg;
    assign tick = tick_reg;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Bench for led_mode_ctrl: directed scenarios followed by random button
// activity. A reference model pushes the expected outputs for every clock
// edge into a queue; a monitor pops one entry per cycle and compares.
module tb_led_mode_ctrl;

    localparam int HF = 10;
    localparam int DB = 3;

    logic       clk      = 1'b0;
    logic       rst_btn  = 1'b1;
    logic       mode_btn = 1'b0;
    logic       LED;
    logic [1:0] mode;
    logic       tick;

    always #4 clk = ~clk;

    led_mode_ctrl #(
        .half_freq (HF),
        .W         (4),
        .DB_CYCLES (DB),
        .DBW       (2)
    ) dut (
        .clk      (clk),
        .rst_btn  (rst_btn),
        .mode_btn (mode_btn),
        .LED      (LED),
        .mode     (mode),
        .tick     (tick)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic       led;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: edge index, recent button samples (newest
    // first), debounced level, pending press, mode and the edge it began on.
    int n_edge  = 0;
    bit hist[$];
    bit m_stable = 1'b0;
    bit m_rose   = 1'b0;
    int m_mode   = 0;
    int m_entry  = 0;

    // Reference model: evaluated once per rising edge.
    always @(posedge clk) begin : model
        exp_t e;
        int   el;
        int   t;
        bit   all_diff;
        bit   press;
        n_edge++;
        if (rst_btn) begin
            hist.delete();
            for (int i = 0; i <= DB; i++) hist.push_back(1'b0);
            m_stable = 1'b0;
            m_rose   = 1'b0;
            m_mode   = 0;
            m_entry  = n_edge;
        end else begin
            press  = m_rose;
            m_rose = 1'b0;
            // The synchronized level seen at an edge is the button sampled two
            // edges earlier; the level flips after DB consecutive disagreements.
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++)
                if (hist[1 + k] == m_stable) all_diff = 1'b0;
            if (all_diff) begin
                m_stable = ~m_stable;
                m_rose   = m_stable;
            end
            hist.push_front(mode_btn);
            void'(hist.pop_back());
            if (press) begin
                m_mode  = (m_mode + 1) % 4;
                m_entry = n_edge;
            end
        end
        el     = n_edge - m_entry;
        e.mode = 2'(m_mode);
        if (m_mode >= 2) begin
            t      = (m_mode == 2) ? HF : HF / 4;
            e.led  = ((el / t) % 2) == 0;
            e.tick = (el > 0) && ((el % t) == 0);
        end else begin
            e.led  = (m_mode == 1);
            e.tick = 1'b0;
        end
        exp_q.push_back(e);
    end

    // Monitor: compare DUT outputs against the model midway through the cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({mode, LED, tick} !== {e.mode, e.led, e.tick}) begin
                failures++;
                if (failures <= 20)
                    $display("FAIL outputs edge=%0d mode/LED/tick got %0d/%0d/%0d expected %0d/%0d/%0d",
                             n_edge, mode, LED, tick, e.mode, e.led, e.tick);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int hold, input int gap);
        mode_btn = 1'b1;
        cyc(hold);
        mode_btn = 1'b0;
        cyc(gap);
    endtask

    initial begin
        bit aligned;
        int r;

        // Reset held while the button toggles, then idle.
        rst_btn = 1'b1;
        for (int i = 0; i < 13; i++) begin
            mode_btn = i[0];
            @(negedge clk);
            checks++;
            if ({mode, LED, tick} !== 4'b0000) begin
                failures++;
                $display("FAIL reset state edge=%0d mode/LED/tick got %0d/%0d/%0d expected 0/0/0",
                         n_edge, mode, LED, tick);
            end
        end
        mode_btn = 1'b0;
        rst_btn  = 1'b0;
        cyc(125);

        // OFF -> SOLID with a long hold, SOLID -> SLOW, SLOW -> FAST, FAST -> OFF.
        press_btn(70, 10);
        press_btn(10, 60);
        press_btn(10, 30);
        press_btn(10, 30);

        // Short glitches that must be rejected.
        repeat (6) begin
            mode_btn = 1'b1;
            cyc(2);
            mode_btn = 1'b0;
            cyc(5);
        end

        // Reach SLOW, then time a press to land on a terminal-count edge.
        press_btn(10, 20);
        press_btn(10, 15);
        aligned = 1'b0;
        for (int i = 0; i < 40 && !aligned; i++) begin
            if (m_mode == 2 && ((n_edge + 1 + DB + 2 - m_entry) % HF) == 0)
                aligned = 1'b1;
            else
                @(negedge clk);
        end
        checks++;
        if (!aligned) begin
            failures++;
            $display("FAIL wait expired edge=%0d no SLOW terminal-count alignment within 40 cycles mode=%0d",
                     n_edge, mode);
        end
        press_btn(12, 15);

        // Reset in the middle of a FAST blink.
        cyc(7);
        rst_btn = 1'b1;
        cyc(1);
        rst_btn = 1'b0;
        cyc(20);

        // Random button activity with occasional resets.
        repeat (80) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) begin
                press_btn(int'($urandom_range(1, 8)), int'($urandom_range(1, 30)));
            end else if (r < 9) begin
                cyc(int'($urandom_range(5, 40)));
            end else begin
                rst_btn = 1'b1;
                cyc(int'($urandom_range(1, 3)));
                rst_btn = 1'b0;
                cyc(int'($urandom_range(1, 10)));
            end
        end

        mode_btn = 1'b0;
        cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Mode controller for the board status LED. A raw push-button steps the LED through four display modes: OFF, SOLID, SLOW blink and FAST blink. The block contains its own half-period timebase, the button synchronizer and debouncer, and the mode state machine. It sits between the board pins (clock, reset button, mode button) and the LED pin, and exposes the current mode and a timebase tick for status and debug.

Parameters:
- half_freq, default 50_000_000: clk cycles per SLOW half-period (1 Hz blink at 100 MHz). Must be >= 4.
- W, default 26: width of the timebase counter. Must hold half_freq-1.
- DB_CYCLES, default 1_000_000: number of cycles a new button level must persist before it is accepted. Must be >= 2.
- DBW, default 20: width of the debounce counter. Must hold DB_CYCLES-1.

Ports:
- clk, input, 1: single system clock, rising edge.
- rst_btn, input, 1: reset, synchronous, active-high.
- mode_btn, input, 1: raw, asynchronous mode push-button. Active-high.
- LED, output, 1: LED drive.
- mode, output, 2: current mode. 0=OFF, 1=SOLID, 2=SLOW, 3=FAST.
- tick, output, 1: one-cycle pulse at each blink half-period boundary.

Behaviour:
- Reset (rst_btn sampled high at a clk edge) clears every register: sync flops, debounce counter, stable level and its delayed copy, timebase counter, mode, LED and tick. Reset outputs: mode=0, LED=0, tick=0. Reset has priority over all other events, including in mid-debounce or mid-blink.
- Synchronizer: two flops, s1 then s2, on mode_btn.
- Debouncer: registers stable and db_cnt.
  - If s2 == stable, db_cnt is set to 0.
  - Else if db_cnt == DB_CYCLES-1, stable is set to s2 and db_cnt to 0.
  - Else db_cnt increments by 1.
  - Any differing pulse shorter than DB_CYCLES cycles at s2 is ignored.
- Press detection: press = stable & ~stable_d, where stable_d is stable delayed by one register. Only rising edges count, so a held button gives exactly one press and a release gives none.
- Press latency: a clean rising edge of mode_btn first sampled at edge E advances mode at edge E+DB_CYCLES+2.
- Mode FSM: states OFF → SOLID → SLOW → FAST → OFF. The FSM advances on press and holds otherwise.
- Terminal count T: half_freq in SLOW, half_freq>>2 in FAST.
- Timebase counter:
  - Held at 0 in OFF and SOLID.
  - In SLOW and FAST it counts 0..T-1 and wraps to 0.
  - At the edge where the counter equals T-1, LED toggles and tick is registered high for one cycle.
- LED by mode:
  - OFF: LED=0.
  - SOLID: LED=1.
  - SLOW and FAST: square wave with period 2T cycles and 50% duty.
- Mode entry: on the edge where mode advances, the counter is cleared and LED is loaded with the entry value of the new mode. Entry values: OFF=0, SOLID=1, SLOW=1, FAST=1 (blink starts in the on phase). tick is 0 on that edge.
- Press coinciding with a terminal count: the mode change wins. There is no toggle and no tick on that edge.
- Outputs are all registered. There is no combinational path from any input to any output.

Test Plan:
All scenarios use half_freq=10, W=4, DB_CYCLES=3, DBW=2, with an 8 ns clk.
1. Reset: hold rst_btn=1 for 100 ns with mode_btn toggling → LED=0, mode=0, tick=0 throughout. After release with no press, outputs are unchanged for 1000 ns.
2. Single press: mode_btn 0→1, held → mode=1 exactly 5 edges after the edge where mode_btn is first sampled high, and LED=1. Holding the button for 500 ns more → mode stays 1.
3. SLOW blink: a second clean press → mode=2 and LED=1 on entry. LED then toggles every 10 cycles (80 ns half-period). tick pulses once per toggle, each pulse 1 cycle wide.
4. FAST blink and wrap: a third press → mode=3 and LED toggles every 2 cycles. A fourth press → mode=0, LED=0, tick stays 0.
5. Glitch rejection: 2-cycle pulses on mode_btn, separated by more than 3 cycles → no mode change.
6. Edge cases:
   - Press timed so the mode advances on the same edge as a SLOW terminal count → mode=3, LED=1, tick=0 on that edge.
   - rst_btn asserted mid-blink → LED=0 and mode=0 after the next edge.
